// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle for cache_mem_arbiter.
// slave = the arbiter, master = caches plus RAM model driving the other side.
interface cache_mem_arbiter_if #(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]       iREN;
  logic [CPUS-1:0][31:0] iaddr;
  logic [CPUS-1:0]       dREN;
  logic [CPUS-1:0]       dWEN;
  logic [CPUS-1:0][31:0] daddr;
  logic [CPUS-1:0][31:0] dstore;
  logic [CPUS-1:0]       iwait;
  logic [CPUS-1:0]       dwait;
  logic [CPUS-1:0][31:0] iload;
  logic [CPUS-1:0][31:0] dload;
  logic                  ramREN;
  logic                  ramWEN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramstore;
  logic [1:0]            ramstate;
  logic [31:0]           ramload;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises I/D cache requests from CPUS cores onto a single RAM port.
// Writes beat reads beat fetches; round-robin across cores within a kind.
module cache_mem_arbiter #(
  parameter int CPUS = 2
) (
  input logic                CLK,
  input logic                nRST,
  cache_mem_arbiter_if.slave bus
);
  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic {IDLE, SERVE} state_t;
  typedef enum logic [1:0] {K_DW = 2'd0, K_DR = 2'd1, K_IR = 2'd2} kind_t;

  typedef struct packed {
    kind_t         kind;
    logic [CW-1:0] core;
  } grant_t;

  state_t        state_q, state_d;
  grant_t        gnt_q, gnt_d;
  logic [CW-1:0] rr_q, rr_d;

  logic [CPUS-1:0] wr_m, rd_m, if_m;
  logic            live, done;
  logic            ram_ren, ram_wen;
  logic [31:0]     ram_addr, ram_store;

  // First requester at or after ptr, wrapping; m is known non-zero by the caller.
  function automatic logic [CW-1:0] rr_pick(input logic [CPUS-1:0] m,
                                            input logic [CW-1:0]   ptr);
    logic [CW-1:0] r;
    logic [CW-1:0] j;
    logic          found;
    r     = '0;
    j     = ptr;
    found = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      if (!found && m[j]) begin
        found = 1'b1;
        r     = j;
      end
      j = (j == CW'(CPUS - 1)) ? '0 : j + 1'b1;
    end
    return r;
  endfunction

  // A core asserting both dWEN and dREN competes only as a writer.
  assign wr_m = bus.dWEN;
  assign rd_m = bus.dREN & ~bus.dWEN;
  assign if_m = bus.iREN;

  always_comb begin
    live = 1'b0;
    case (gnt_q.kind)
      K_DW:    live = bus.dWEN[gnt_q.core];
      K_DR:    live = bus.dREN[gnt_q.core];
      K_IR:    live = bus.iREN[gnt_q.core];
      default: live = 1'b0;
    endcase
  end

  // RAM side follows the granted core's live address/data; nothing is latched.
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    done      = 1'b0;
    if (state_q == SERVE && live) begin
      case (gnt_q.kind)
        K_DW: begin
          ram_wen   = 1'b1;
          ram_addr  = bus.daddr[gnt_q.core];
          ram_store = bus.dstore[gnt_q.core];
        end
        K_DR: begin
          ram_ren   = 1'b1;
          ram_addr  = bus.daddr[gnt_q.core];
          ram_store = bus.dstore[gnt_q.core];
        end
        default: begin
          ram_ren  = 1'b1;
          ram_addr = bus.iaddr[gnt_q.core];
        end
      endcase
      done = (bus.ramstate == RS_ACCESS) || (bus.ramstate == RS_ERROR);
    end
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (|wr_m) begin
          gnt_d   = '{kind: K_DW, core: rr_pick(wr_m, rr_q)};
          state_d = SERVE;
        end else if (|rd_m) begin
          gnt_d   = '{kind: K_DR, core: rr_pick(rd_m, rr_q)};
          state_d = SERVE;
        end else if (|if_m) begin
          gnt_d   = '{kind: K_IR, core: rr_pick(if_m, rr_q)};
          state_d = SERVE;
        end
      end
      SERVE: begin
        // A dropped request is an abort: back to IDLE without touching rr.
        if (!live) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          rr_d    = (gnt_q.core == CW'(CPUS - 1)) ? '0 : gnt_q.core + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  // Only the granted port sees wait=0, and only in its completion cycle.
  always_comb begin
    bus.iwait = '1;
    bus.dwait = '1;
    bus.iload = '0;
    bus.dload = '0;
    if (done) begin
      if (gnt_q.kind == K_IR) begin
        bus.iwait[gnt_q.core] = 1'b0;
        bus.iload[gnt_q.core] = bus.ramload;
      end else begin
        bus.dwait[gnt_q.core] = 1'b0;
        bus.dload[gnt_q.core] = bus.ramload;
      end
    end
  end
endmodule
